dac_sample_pacer: RTL
=====================

Name: dac_sample_pacer

Overview:
- Sits directly upstream of the dual-channel DA2 DAC driver top.
- Accepts paired signed filter-output samples through a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample to 12-bit offset-binary with saturation.
- Presents the result on value0/value1 with a one-cycle update pulse at a fixed sample rate, so the DAC frame cadence is decoupled from filter output timing.

Parameters:
- IN_W, 18: signed input sample width.
- SHIFT, 4: arithmetic right shift applied before saturation.
- DEPTH, 8: FIFO depth in sample pairs. Must be a power of 2, at least 2.
- SAMPLE_DIV, 2500: clk cycles between update slots (2500 gives 40 kHz at 100 MHz). Must be at least 512 so a DA2 frame completes between updates.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept a pair
- in_ch0  in  IN_W  signed sample, channel 0
- in_ch1  in  IN_W  signed sample, channel 1
- value0  out  12  offset-binary DAC code, channel 0
- value1  out  12  offset-binary DAC code, channel 1
- update  out  1  one-cycle strobe to the DAC driver
- underrun  out  1  one-cycle pulse when a slot finds the FIFO empty
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release):
  - value0 = value1 = 12'h800 (midscale)
  - update = 0, underrun = 0
  - FIFO emptied: level = 0, pointers = 0
  - tick counter = 0
  - in_ready = 0 while rst is low
- Handshake:
  - in_ready = (level != DEPTH).
  - Push occurs on a rising edge with in_valid and in_ready both high.
  - in_ch0/in_ch1 are stored as a pair.
  - Data offered while in_ready is low is not consumed; the source holds it.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick = (count == SAMPLE_DIV-1).
  - Free-running from reset release; unaffected by FIFO state.
- Slot on a tick cycle T:
  - FIFO non-empty: pop the head pair. At the edge ending T, value0/value1 load the converted pair. update is high during cycle T+1 only.
  - FIFO empty: value0/value1 hold, update stays 0, underrun is high during T+1 only.
- Simultaneous push and pop in the same cycle: both occur and level is unchanged.
  - When full, a pop frees space, but in_ready was low that cycle, so no push occurs; level becomes DEPTH-1.
  - When empty, a same-cycle push does not satisfy the pop. The slot counts as an underrun and level becomes 1.
- Conversion, identical per channel:
  - s = in >>> SHIFT (sign-preserving).
  - Saturate: s > 2047 → 2047; s < -2048 → -2048.
  - out = s[11:0] with bit 11 inverted, i.e. s + 2048.
  - Range: -2048 → 12'h000, 0 → 12'h800, 2047 → 12'hFFF.
- update spacing: consecutive updates are exactly SAMPLE_DIV cycles apart while the FIFO stays non-empty.
- value0/value1 change only in the cycle update rises and remain stable until the next update.
- Reset mid-operation: all in-flight and queued pairs are discarded; outputs return to their reset values immediately.
- level is registered and reflects pushes/pops after each edge.

Test Plan:
- Reset, then release with no input → value0 = value1 = 12'h800, update never high, underrun pulses once every 2500 cycles.
- Push one pair (ch0 = 18'h01230, ch1 = 18'h3FFF0) before the first tick → at the next slot value0 = 12'h923, value1 = 12'h7FF, update high exactly 1 cycle, level 1→0.
- Push (18'h1FFFF, 18'h20000) → value0 = 12'hFFF, value1 = 12'h000 (saturation both ends). Push (0, 18'h07FF0) → 12'h800, 12'hFFF.
- Hold in_valid high with no tick for 10 cycles → 8 pairs accepted, in_ready falls with level = 8. At the tick, a pop occurs, level = 7, and in_ready rises the following cycle.
- Preload 3 pairs → updates occur at exactly 2500-cycle spacing carrying the pairs in FIFO order. The 4th slot raises underrun and values hold at the 3rd pair.
- Assert rst mid-stream with level = 5 → outputs 12'h800 asynchronously, level 0, tick counter restarts, no stale update after release.

Source files
------------

// File: rtl/dac_sample_pacer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dac_sample_pacer
// Description : Buffers paired signed samples and releases them to a dual DAC
//               driver as 12-bit offset-binary codes at a fixed slot rate.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_pacer #(
  parameter int IN_W       = 18,
  parameter int SHIFT      = 4,
  parameter int DEPTH      = 8,
  parameter int SAMPLE_DIV = 2500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_ch0,
  input  logic [IN_W-1:0]            in_ch1,
  output logic [11:0]                value0,
  output logic [11:0]                value1,
  output logic                       update,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(SAMPLE_DIV);
  localparam logic signed [IN_W-1:0] c_sat_hi = IN_W'(2047);
  localparam logic signed [IN_W-1:0] c_sat_lo = IN_W'(-2048);

  logic [IN_W-1:0] r_mem0 [DEPTH];
  logic [IN_W-1:0] r_mem1 [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic [c_cw-1:0] r_count;
  logic [11:0]     r_value0;
  logic [11:0]     r_value1;
  logic            r_update;
  logic            r_underrun;

  logic w_tick;
  logic w_empty;
  logic w_push;
  logic w_pop;

  function automatic logic [11:0] to_offset_binary(input logic [IN_W-1:0] x);
    logic signed [IN_W-1:0] s;
    s = $signed(x) >>> SHIFT;
    if (s > c_sat_hi)      return 12'hFFF;
    else if (s < c_sat_lo) return 12'h000;
    else                   return {~s[11], s[10:0]};
  endfunction

  assign w_tick   = (r_count == c_cw'(SAMPLE_DIV - 1));
  assign w_empty  = (r_level == '0);
  assign in_ready = rst & (r_level != (c_aw+1)'(DEPTH));
  assign w_push   = in_valid & in_ready;
  // Pop decision uses pre-edge occupancy, so a same-cycle push never feeds an empty slot.
  assign w_pop    = w_tick & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem0[r_wr_ptr] <= in_ch0;
      r_mem1[r_wr_ptr] <= in_ch1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_value0   <= 12'h800;
      r_value1   <= 12'h800;
      r_update   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_count    <= w_tick ? '0 : r_count + 1'b1;
      r_update   <= w_pop;
      r_underrun <= w_tick & w_empty;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_value0 <= to_offset_binary(r_mem0[r_rd_ptr]);
        r_value1 <= to_offset_binary(r_mem1[r_rd_ptr]);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign value0   = r_value0;
  assign value1   = r_value1;
  assign update   = r_update;
  assign underrun = r_underrun;
  assign level    = r_level;

endmodule
`default_nettype wire
